cifrador_8bits: RTL and testbench
=================================

// Module: cifrador_8bits
// PURPOSE
//   Registered 8-bit block cipher (substitution-permutation network) with a fixed key.
//   Takes an 8-bit plaintext on individual bit ports A7..A0 and produces the ciphertext
//   on Y7..Y0 one clock later.
//   Used as a lightweight scrambler stage between a parallel data source and its sink.
// PARAMETERS
//   KEY     8'hA5  cipher key; round key r = rotl(KEY, r)
//   ROUNDS  2      number of SPN rounds, legal range 1..7
// PORTS
//   clk          in   1  system clock, rising edge
//   rst          in   1  reset, asynchronous, active-high
//   A7..A0       in   1  plaintext bits; A7 = MSB, A0 = LSB
//   Y7..Y0       out  1  ciphertext bits, registered; Y7 = MSB, Y0 = LSB
// BEHAVIOUR
//   - Interface: one clock; reset is asynchronous and active-high.
//   - Packing: a = {A7,...,A0} and {Y7,...,Y0} = y_q.
//   - Datapath is combinational from a; all rounds are unrolled in one cycle.
//       x = a
//       for r = 0..ROUNDS-1:  x = P(S(x ^ rotl(KEY, r)))
//       y = x ^ rotl(KEY, ROUNDS)   (final whitening)
//   - S: applies the 4-bit S-box independently to x[7:4] and x[3:0].
//     Table, input 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
//   - P: 8-bit rotate-left by 3, i.e. {x[4:0], x[7:5]}.
//   - rotl(k, n): 8-bit rotate-left of k by n positions.
//   - Register and latency:
//       * y_q <= y on every rising clk edge; no enable; no handshake.
//       * Latency is exactly 1 cycle.
//       * Throughput is 1 block per cycle.
//       * Inputs are sampled only at the clock edge.
//   - Reset:
//       * rst=1 clears y_q to 8'h00 immediately, without waiting for clk.
//       * y_q holds 8'h00 while rst stays high.
//       * The first edge after rst falls loads the cipher of the current inputs.
//       * Reset mid-stream discards the in-flight result.
//   - Input changes between edges have no effect on Y; Y changes only on a clk edge or on rst.
//   - No X propagation from internal state; the cipher is a pure function of A, KEY and ROUNDS.
// STRUCTURE
//   - Package cifrador_pkg holds:
//       * the S-box table (16 x 4-bit localparam array)
//       * function sbox4
//       * function rotl8(value, n)
//       * function perm8 (rotl by 3)
//       * default KEY constant 8'hA5
//   - Sub-module cifrador_round: purely combinational.
//       * Ports: in[7:0], round_key[7:0], out[7:0].
//       * Computes out = perm8({sbox4(hi), sbox4(lo)}) of in ^ round_key.
//   - Top level:
//       * packs the A bits into a
//       * generate-loops ROUNDS instances of cifrador_round
//       * applies the whitening XOR
//       * holds the 8-bit output register
//       * unpacks y_q onto Y7..Y0
// TESTING  (KEY=8'hA5, ROUNDS=2; check Y one clk edge after applying A)
//   1. rst=1 asynchronously with any A -> Y=8'h00 before the next edge; held while rst=1.
//   2. A=8'h00, rst=0, one edge -> Y=8'hB4.
//      Intermediates: 87 after round 0, 22 after round 1.
//   3. A=8'hFF, one edge -> Y=8'h4B.
//   4. A=8'hAA, one edge -> Y=8'hAE.
//   5. A=8'h55, one edge -> Y=8'hED.
//   6. Drive A=00, FF, AA, 55 on consecutive edges -> Y=B4, 4B, AE, ED, each lagging A by 1 cycle.
//      Then assert rst between edges -> Y drops to 00 at once.
//      Toggling A with no clk edge -> Y unchanged.

Source files
------------

// File: rtl/cifrador_pkg.sv
// Shared constants and helpers for the 8-bit SPN scrambler: S-box, rotations, key.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package cifrador_pkg;

  // Key used when the top level is not given one explicitly
  localparam logic [7:0] KEY_DEFAULT = 8'hA5;

  // 4-bit substitution box, indexed by the input nibble
  localparam logic [3:0] SBOX [0:15] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic logic [3:0] sbox4(input logic [3:0] nib);
    return SBOX[nib];
  endfunction

  // Rotate an 8-bit value left by n; n is 3 bits wide, so it covers every distinct rotation
  function automatic logic [7:0] rotl8(input logic [7:0] value, input logic [2:0] n);
    logic [15:0] dbl;
    dbl = {value, value} << n;
    return dbl[15:8];
  endfunction

  // Bit permutation layer: fixed rotate-left by 3
  function automatic logic [7:0] perm8(input logic [7:0] value);
    return {value[4:0], value[7:5]};
  endfunction

endpackage

// File: rtl/cifrador_round.sv
// One SPN round: key mix, nibble-wise S-box substitution, then the rotate-by-3 permutation.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the inputs continuously.
module cifrador_round
  import cifrador_pkg::*;
(
  input  logic [7:0] in,
  input  logic [7:0] round_key,
  output logic [7:0] out
);

  logic [7:0] mixed;
  logic [7:0] subst;

  assign mixed = in ^ round_key;
  // Both nibbles go through the same S-box independently
  assign subst = {sbox4(mixed[7:4]), sbox4(mixed[3:0])};
  assign out   = perm8(subst);

endmodule

// File: rtl/cifrador_8bits.sv
// Fixed-key 8-bit SPN scrambler: all rounds unrolled, result captured in one output register.
// Latency: exactly 1 clk cycle from A sampled to Y updated; one block per cycle.
// Backpressure: none; no enable or handshake, a new block is accepted on every edge.
module cifrador_8bits
  import cifrador_pkg::*;
#(
  parameter logic [7:0] KEY    = KEY_DEFAULT,
  // Legal range is 1..7; round keys and whitening rotate the key by the round index
  parameter int          ROUNDS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic A7,
  input  logic A6,
  input  logic A5,
  input  logic A4,
  input  logic A3,
  input  logic A2,
  input  logic A1,
  input  logic A0,
  output logic Y7,
  output logic Y6,
  output logic Y5,
  output logic Y4,
  output logic Y3,
  output logic Y2,
  output logic Y1,
  output logic Y0
);

  logic [7:0] a;
  logic [7:0] y;
  logic [7:0] y_q;

  // stage[r] is the state entering round r; stage[ROUNDS] leaves the last round
  logic [7:0] stage [0:ROUNDS];

  assign a        = {A7, A6, A5, A4, A3, A2, A1, A0};
  assign stage[0] = a;

  for (genvar r = 0; r < ROUNDS; r++) begin : g_round
    cifrador_round u_round (
      .in        (stage[r]),
      .round_key (rotl8(KEY, 3'(r))),
      .out       (stage[r+1])
    );
  end

  // Final whitening uses the next key rotation after the last round key
  assign y = stage[ROUNDS] ^ rotl8(KEY, 3'(ROUNDS));

  // Output register; reset clears it at once and discards any in-flight block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q <= 8'h00;
    end else begin
      y_q <= y;
    end
  end

  assign {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0} = y_q;

endmodule

// File: tb/tb_cifrador_8bits.sv
// Self-checking bench for cifrador_8bits: directed vectors plus a randomized stream.
// Latency: expects Y to reflect A sampled one clk edge earlier.
// Backpressure: none exercised; the design has no handshake.
module tb_cifrador_8bits;

  localparam logic [7:0] KEY    = 8'hA5;
  localparam int         ROUNDS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a_drv = 8'h3C;
  logic [7:0] y_obs;

  int checks = 0;
  int errors = 0;

  logic A7, A6, A5, A4, A3, A2, A1, A0;
  logic Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0;

  assign {A7, A6, A5, A4, A3, A2, A1, A0} = a_drv;
  assign y_obs = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};

  cifrador_8bits #(.KEY(KEY), .ROUNDS(ROUNDS)) dut (
    .clk (clk), .rst (rst),
    .A7 (A7), .A6 (A6), .A5 (A5), .A4 (A4),
    .A3 (A3), .A2 (A2), .A1 (A1), .A0 (A0),
    .Y7 (Y7), .Y6 (Y6), .Y5 (Y5), .Y4 (Y4),
    .Y3 (Y3), .Y2 (Y2), .Y1 (Y1), .Y0 (Y0)
  );

  always #5 clk = ~clk;

  // Reference cipher written with plain integer arithmetic
  int sbox_tbl [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  function automatic int rot_left(int v, int n);
    int m;
    m = n % 8;
    return ((v * (1 << m)) + (v / (1 << (8 - m)))) % 256;
  endfunction

  function automatic logic [7:0] ref_cipher(int plain);
    int x;
    x = plain;
    for (int r = 0; r < ROUNDS; r++) begin
      x = x ^ rot_left(int'(KEY), r);
      x = sbox_tbl[x / 16] * 16 + sbox_tbl[x % 16];
      x = rot_left(x, 3);
    end
    x = x ^ rot_left(int'(KEY), ROUNDS);
    return 8'(x);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, then sample just after the next rising edge
  task automatic step(input logic [7:0] val);
    @(negedge clk);
    a_drv = val;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] vec_in  [4] = '{8'h00, 8'hFF, 8'hAA, 8'h55};
  logic [7:0] vec_out [4] = '{8'hB4, 8'h4B, 8'hAE, 8'hED};
  logic [7:0] held;
  logic [7:0] prev;

  initial begin
    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1 check("async_reset", y_obs, 8'h00);
    repeat (2) @(posedge clk);
    a_drv = 8'hFF;
    #1 check("reset_hold", y_obs, 8'h00);

    // Release reset; first edge loads the cipher of the current input
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(vec_in[i]);
      check($sformatf("vector_%0h", vec_in[i]), y_obs, vec_out[i]);
      check($sformatf("model_%0h", vec_in[i]), y_obs, ref_cipher(int'(vec_in[i])));
    end

    // Back-to-back stream: each output lags its input by one edge
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_drv = vec_in[i];
      if (i > 0) check($sformatf("stream_lag_%0d", i), y_obs, vec_out[i-1]);
      @(posedge clk);
      #1 check($sformatf("stream_%0d", i), y_obs, vec_out[i]);
    end

    // Input toggles with no edge leave Y alone
    @(negedge clk);
    held = y_obs;
    a_drv = 8'h12; #1;
    a_drv = 8'hC7; #1;
    check("no_edge_hold", y_obs, held);

    // Reset between edges drops Y immediately and discards the in-flight block
    rst = 1'b1;
    #1 check("midstream_reset", y_obs, 8'h00);
    @(posedge clk);
    #1 check("midstream_reset_hold", y_obs, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    a_drv = 8'h00;
    @(posedge clk);
    #1 check("post_reset_load", y_obs, 8'hB4);

    // Randomized stream against the reference model
    prev = a_drv;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("rand_hold", y_obs, ref_cipher(int'(prev)));
      a_drv = 8'($urandom_range(0, 255));
      prev = a_drv;
      @(posedge clk);
      #1 check("rand", y_obs, ref_cipher(int'(prev)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
